spi_slave_responder: RTL and testbench
======================================

Name: spi_slave_responder

Overview:
- SPI target (slave) that is the counterpart of the team's SPI master driver; it runs entirely in the system clock domain and oversamples the SPI lines.
- Receives MOSI words and presents them to user logic as single-cycle valid pulses.
- Returns user-supplied words on MISO through a one-entry TX buffer with a valid/ready handshake.
- Sits between the board-level SPI pins and register or command logic.

Parameters:
P_DATA_WIDTH, 8, bits per SPI word, MSB first, >=2
P_CPOL, 0, SCLK idle level
P_CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge
P_IDLE_DATA, {P_DATA_WIDTH{1'b1}}, word shifted out when the TX buffer is empty at a word start

Ports:
clk  input  1  system clock; must be >= 4x SCLK frequency
rst_n  input  1  asynchronous active-low reset
i_spi_clk  input  1  SCLK from master, asynchronous
i_spi_cs  input  1  chip select, active low, asynchronous
i_spi_mosi  input  1  master-out data, asynchronous
o_spi_miso  output  1  slave-out data
i_user_data  input  P_DATA_WIDTH  word to transmit
i_user_valid  input  1  i_user_data valid
o_user_ready  output  1  TX buffer empty; transfer occurs when valid & ready
o_user_read_data  output  P_DATA_WIDTH  last complete received word
o_user_read_valid  output  1  one-clk pulse when o_user_read_data updates

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Synchronisers:
  - 2-flop synchronisers on SCLK, CS and MOSI.
  - A third flop on SCLK and on CS provides edge detection.
  - All decisions use the synchronised values, giving 2-3 clk of input latency.
- Edge mapping:
  - Leading edge is rising when P_CPOL=0 and falling when P_CPOL=1.
  - Sample edge is the leading edge if P_CPHA=0, otherwise the trailing edge.
  - Shift edge is the opposite edge to the sample edge.
- CS high (deselected):
  - SCLK edges are ignored.
  - Bit counter is 0 and o_spi_miso holds its last value.
- CS falling edge:
  - Bit counter is cleared.
  - TX shift register loads the TX buffer if full, which empties the buffer; otherwise it loads P_IDLE_DATA.
  - P_CPHA=0: o_spi_miso is driven with the loaded MSB on the next clk.
- Sample edge:
  - Synchronised MOSI is shifted into the RX shift register LSB.
  - Bit counter increments.
  - When the counter reaches P_DATA_WIDTH: o_user_read_data is loaded with the full word on the next clk, o_user_read_valid pulses for exactly 1 clk, and the counter returns to 0.
- Shift edge, P_CPHA=0:
  - Mid-word: the TX shift register shifts left and o_spi_miso takes the new MSB.
  - Shift edge following the last sample of a word: the next word is reloaded (buffer or P_IDLE_DATA) instead of shifting.
- Shift edge, P_CPHA=1:
  - o_spi_miso takes the TX MSB, then the register shifts.
  - The first shift edge of each word reloads from the buffer or P_IDLE_DATA before presenting the MSB.
- Handshake:
  - o_user_ready = TX buffer empty.
  - valid & ready captures i_user_data; ready drops on the next clk.
  - A buffer load and a consume in the same clk cannot occur, because ready is low while the buffer is full.
  - The user may load while CS is low; the word takes effect at the next word start.
- CS rising mid-word:
  - The partial RX word is discarded with no valid pulse.
  - The bit counter clears.
  - The TX buffer contents are retained.
- Simultaneous edges: a CS rise in the same clk as a sample edge takes priority; the edge is ignored.
- Reset values:
  - o_spi_miso=0, o_user_ready=1, o_user_read_data=0, o_user_read_valid=0.
  - Shift registers cleared, counter 0, TX buffer empty.
  - Synchronisers reset: CS to 1, SCLK to P_CPOL.
- Reset mid-transfer aborts the transfer immediately. No valid pulse is produced until a fresh CS falling edge.

Optional Feature:
- Macro SPI_SLAVE_MISO_OE_EN.
- Defined:
  - Adds output port o_spi_miso_oe (1 bit).
  - o_spi_miso_oe is high from the clk after the synchronised CS fall until the clk after the synchronised CS rise, and 0 in reset.
  - The top level uses it to tristate MISO on a shared bus.
- Undefined: the port is absent and MISO is always driven.

Decomposition:
- Shared header spi_defines.vh holds:
  - mode constants SPI_MODE0..3 as {CPOL,CPHA};
  - default width 8;
  - the minimum oversampling ratio, 4.
- One sub-module, spi_sync_edge:
  - 2-flop synchronizer plus delay flop.
  - Outputs: sync level, rise pulse, fall pulse.
  - Reset value is a parameter.
  - Instantiated for SCLK and CS; MOSI uses only the synchronizer.

Test Plan:
- Mode 0, clk = 8x SCLK: user loads 0xA5, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; o_user_read_data=0x3C with a single 1-clk valid; ready re-asserts after the CS fall.
- Mode 3: TX buffer empty, master sends 0x81 -> MISO returns 0xFF (P_IDLE_DATA); read_data=0x81.
- Two back-to-back words with CS held low in mode 1: user loads 0x12, then loads 0x34 while ready -> MISO carries 0x12 then 0x34; two valid pulses with 0x55 then 0xAA for MOSI 0x55,0xAA.
- CS deasserted after 5 bits -> no valid pulse, read_data unchanged; next full transfer of 0xC3 is received correctly.
- rst_n asserted mid-word -> all outputs at reset values within the same clk; a subsequent full mode-2 transfer of 0x5A passes.
- With SPI_SLAVE_MISO_OE_EN -> oe tracks CS with 3-clk latency; without it -> the build has no oe port and lint is clean.

Source files
------------

// File: rtl/spi_slave_responder_pkg.sv
// ---------------------------------------------------------------------------
// Module : spi_slave_responder_pkg
// Brief  : Shared SPI constants (mode encodings, default width, oversampling)
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_slave_responder_pkg;

    // Mode encoding is {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam int SPI_DEFAULT_WIDTH  = 8;
    localparam int SPI_MIN_OVERSAMPLE = 4;

    function automatic logic [1:0] spi_mode(input logic cpol, input logic cpha);
        return {cpol, cpha};
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// Module : spi_sync_edge
// Brief  : Two-flop synchroniser plus delay flop giving level, rise and fall
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_sync_edge
    import spi_slave_responder_pkg::*;
#(
    parameter bit P_RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= P_RESET_VAL;
            sync_q <= P_RESET_VAL;
            dly_q  <= P_RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~dly_q;
    assign fall_o  = ~sync_q & dly_q;

endmodule

`default_nettype wire

// File: rtl/spi_slave_responder.sv
// ---------------------------------------------------------------------------
// Module : spi_slave_responder
// Brief  : Oversampling SPI target with RX valid pulse and one-entry TX buffer.
//          Define SPI_SLAVE_MISO_OE_EN to add the o_spi_miso_oe output.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_slave_responder
    import spi_slave_responder_pkg::*;
#(
    parameter int                      P_DATA_WIDTH = SPI_DEFAULT_WIDTH,
    parameter bit                      P_CPOL       = 1'b0,
    parameter bit                      P_CPHA       = 1'b0,
    parameter logic [P_DATA_WIDTH-1:0] P_IDLE_DATA  = {P_DATA_WIDTH{1'b1}}
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_spi_clk,
    input  logic                    i_spi_cs,
    input  logic                    i_spi_mosi,
    output logic                    o_spi_miso,
`ifdef SPI_SLAVE_MISO_OE_EN
    output logic                    o_spi_miso_oe,
`endif
    input  logic [P_DATA_WIDTH-1:0] i_user_data,
    input  logic                    i_user_valid,
    output logic                    o_user_ready,
    output logic [P_DATA_WIDTH-1:0] o_user_read_data,
    output logic                    o_user_read_valid
);

    localparam int                CNT_W    = $clog2(P_DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(P_DATA_WIDTH - 1);

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_lead, w_trail, w_sample, w_shift, w_load;
    logic [P_DATA_WIDTH-1:0] w_next_word;
    logic [P_DATA_WIDTH-1:0] w_tx_word;
    logic                    w_consume;

    logic mosi_meta_q, mosi_sync_q;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [P_DATA_WIDTH-2:0] rx_shift_q, rx_shift_d;
    logic [P_DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                    miso_q, miso_d;
    logic [P_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [P_DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic                    buf_full_q, buf_full_d;
    logic                    fresh_q, fresh_d;

    spi_sync_edge #(.P_RESET_VAL(P_CPOL)) u_sync_sclk (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (i_spi_clk),
        .level_o (w_sclk_level),
        .rise_o  (w_sclk_rise),
        .fall_o  (w_sclk_fall)
    );

    spi_sync_edge #(.P_RESET_VAL(1'b1)) u_sync_cs (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (i_spi_cs),
        .level_o (w_cs_level),
        .rise_o  (w_cs_rise),
        .fall_o  (w_cs_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            mosi_meta_q <= i_spi_mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign w_lead      = P_CPOL ? w_sclk_fall : w_sclk_rise;
    assign w_trail     = P_CPOL ? w_sclk_rise : w_sclk_fall;
    // A CS rise is already a high level, so edges in that clk are dropped
    assign w_sample    = (P_CPHA ? w_trail : w_lead) & ~w_cs_level & ~w_cs_rise;
    assign w_shift     = (P_CPHA ? w_lead : w_trail) & ~w_cs_level & ~w_cs_rise;
    assign w_next_word = buf_full_q ? buf_data_q : P_IDLE_DATA;
    assign w_load      = i_user_valid & ~buf_full_q;

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        miso_d     = miso_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        buf_data_d = buf_data_q;
        buf_full_d = buf_full_q;
        fresh_d    = fresh_q;
        w_tx_word  = tx_shift_q;
        w_consume  = 1'b0;

        if (w_cs_level) begin
            bit_cnt_d = '0;
        end

        if (w_cs_fall) begin
            bit_cnt_d  = '0;
            w_tx_word  = w_next_word;
            w_consume  = 1'b1;
            tx_shift_d = w_next_word;
            fresh_d    = 1'b1;
            if (!P_CPHA) begin
                miso_d = w_next_word[P_DATA_WIDTH-1];
            end
        end else if (w_sample) begin
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d  = '0;
                rd_data_d  = {rx_shift_q, mosi_sync_q};
                rd_valid_d = 1'b1;
            end else begin
                bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            end
            rx_shift_d = {rx_shift_q[P_DATA_WIDTH-3:0], mosi_sync_q};
        end else if (w_shift) begin
            fresh_d = 1'b0;
            // Counter at zero on a shift edge means a word boundary; the word
            // loaded by the CS fall is kept for the first CPHA=1 word.
            if ((bit_cnt_q == '0) && (!P_CPHA || !fresh_q)) begin
                w_tx_word = w_next_word;
                w_consume = 1'b1;
            end
            if (P_CPHA) begin
                miso_d     = w_tx_word[P_DATA_WIDTH-1];
                tx_shift_d = w_tx_word << 1;
            end else if (w_consume) begin
                miso_d     = w_tx_word[P_DATA_WIDTH-1];
                tx_shift_d = w_tx_word;
            end else begin
                miso_d     = tx_shift_q[P_DATA_WIDTH-2];
                tx_shift_d = tx_shift_q << 1;
            end
        end

        if (w_consume) begin
            buf_full_d = 1'b0;
        end
        if (w_load) begin
            buf_full_d = 1'b1;
            buf_data_d = i_user_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            miso_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            buf_data_q <= '0;
            buf_full_q <= 1'b0;
            fresh_q    <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            miso_q     <= miso_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            buf_data_q <= buf_data_d;
            buf_full_q <= buf_full_d;
            fresh_q    <= fresh_d;
        end
    end

`ifdef SPI_SLAVE_MISO_OE_EN
    logic miso_oe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_oe_q <= 1'b0;
        end else begin
            miso_oe_q <= ~w_cs_level;
        end
    end

    assign o_spi_miso_oe = miso_oe_q;
`endif

    assign o_spi_miso        = miso_q;
    assign o_user_ready      = ~buf_full_q;
    assign o_user_read_data  = rd_data_q;
    assign o_user_read_valid = rd_valid_q;

    // Level output of the SCLK synchroniser is intentionally only observed via edges
    logic w_unused;
    assign w_unused = w_sclk_level;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_responder.sv
// ---------------------------------------------------------------------------
// Module : tb_spi_slave_responder
// Brief  : Directed bench driving all four SPI modes in parallel (clk = 8x SCLK)
// Rev    : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_spi_slave_responder;

    localparam int W    = 8;
    localparam int N    = 4;
    localparam int HALF = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  sclk, cs, mosi, miso, ready, rvalid;
    logic [W-1:0]  rdata [N];
    logic [W-1:0]  udata;
    logic          uvalid;
`ifdef SPI_SLAVE_MISO_OE_EN
    logic [N-1:0]  oe;
`endif

    int            n_tests = 0;
    int            n_fail  = 0;
    int            vcnt [N] = '{default: 0};
    int            base [N];
    logic [W-1:0]  cap  [N];
    logic [W-1:0]  cap1 [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        spi_slave_responder #(
            .P_DATA_WIDTH (W),
            .P_CPOL       (1'((g >> 1) & 1)),
            .P_CPHA       (1'(g & 1))
        ) u_dut (
            .clk               (clk),
            .rst_n             (rst_n),
            .i_spi_clk         (sclk[g]),
            .i_spi_cs          (cs[g]),
            .i_spi_mosi        (mosi[g]),
            .o_spi_miso        (miso[g]),
`ifdef SPI_SLAVE_MISO_OE_EN
            .o_spi_miso_oe     (oe[g]),
`endif
            .i_user_data       (udata),
            .i_user_valid      (uvalid),
            .o_user_ready      (ready[g]),
            .o_user_read_data  (rdata[g]),
            .o_user_read_valid (rvalid[g])
        );
    end

    always @(negedge clk) begin
        for (int m = 0; m < N; m++) begin
            if (rvalid[m]) vcnt[m] <= vcnt[m] + 1;
        end
    end

    function automatic logic f_cpol(input int m);
        return m[1];
    endfunction

    function automatic logic f_cpha(input int m);
        return m[0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_lines();
        for (int m = 0; m < N; m++) sclk[m] = f_cpol(m);
        cs   = '1;
        mosi = '0;
    endtask

    task automatic snap();
        for (int m = 0; m < N; m++) base[m] = vcnt[m];
    endtask

    task automatic user_load(input logic [W-1:0] d);
        int t = 0;
        while (ready != '1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("load_ready_timeout", 32'(ready), 32'hF);
        udata  = d;
        uvalid = 1'b1;
        @(negedge clk);
        uvalid = 1'b0;
    endtask

    task automatic send_bits(input logic [W-1:0] word, input int nbits);
        for (int b = 0; b < nbits; b++) begin
            for (int m = 0; m < N; m++) if (!f_cpha(m)) mosi[m] = word[W-1-b];
            ticks(HALF);
            for (int m = 0; m < N; m++) if (!f_cpha(m)) cap[m] = {cap[m][W-2:0], miso[m]};
            sclk = ~sclk;
            for (int m = 0; m < N; m++) if (f_cpha(m)) mosi[m] = word[W-1-b];
            ticks(HALF);
            for (int m = 0; m < N; m++) if (f_cpha(m)) cap[m] = {cap[m][W-2:0], miso[m]};
            sclk = ~sclk;
        end
    endtask

    task automatic cs_release();
        ticks(HALF);
        cs = '1;
        ticks(8);
    endtask

    task automatic xfer(input logic [W-1:0] word);
        cs = '0;
        send_bits(word, W);
        cs_release();
    endtask

    task automatic check_xfer(input string tag, input logic [W-1:0] exp_miso,
                              input logic [W-1:0] exp_rd, input int exp_pulses);
        for (int m = 0; m < N; m++) begin
            chk($sformatf("%s m%0d miso", tag, m), 32'(cap[m]), 32'(exp_miso));
            chk($sformatf("%s m%0d rdata", tag, m), 32'(rdata[m]), 32'(exp_rd));
            chk($sformatf("%s m%0d pulses", tag, m), 32'(vcnt[m] - base[m]), 32'(exp_pulses));
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        udata  = '0;
        uvalid = 1'b0;
        idle_lines();
        for (int m = 0; m < N; m++) cap[m] = '0;
        ticks(3);
        chk("reset miso",   32'(miso),   32'h0);
        chk("reset ready",  32'(ready),  32'hF);
        chk("reset rvalid", 32'(rvalid), 32'h0);
        for (int m = 0; m < N; m++) chk($sformatf("reset m%0d rdata", m), 32'(rdata[m]), 32'h0);
        rst_n = 1'b1;
        ticks(3);

        // User word 0xA5 out, 0x3C in
        user_load(8'hA5);
        ticks(1);
        chk("a5 ready low", 32'(ready), 32'h0);
        snap();
        xfer(8'h3C);
        check_xfer("a5", 8'hA5, 8'h3C, 1);
        chk("a5 ready back", 32'(ready), 32'hF);

        // Empty buffer returns idle data
        snap();
        xfer(8'h81);
        check_xfer("idle", 8'hFF, 8'h81, 1);

        // Back-to-back words with CS held low
        user_load(8'h12);
        snap();
        cs = '0;
        user_load(8'h34);
        ticks(1);
        chk("b2b ready low", 32'(ready), 32'h0);
        send_bits(8'h55, W);
        for (int m = 0; m < N; m++) cap1[m] = cap[m];
        ticks(HALF);
        for (int m = 0; m < N; m++) begin
            chk($sformatf("b2b1 m%0d miso", m), 32'(cap1[m]), 32'h12);
            chk($sformatf("b2b1 m%0d rdata", m), 32'(rdata[m]), 32'h55);
            chk($sformatf("b2b1 m%0d pulses", m), 32'(vcnt[m] - base[m]), 32'd1);
        end
        send_bits(8'hAA, W);
        cs_release();
        check_xfer("b2b2", 8'h34, 8'hAA, 2);

        // Aborted partial word
        snap();
        cs = '0;
        send_bits(8'hF0, 5);
        cs_release();
        for (int m = 0; m < N; m++) begin
            chk($sformatf("part m%0d rdata", m), 32'(rdata[m]), 32'hAA);
            chk($sformatf("part m%0d pulses", m), 32'(vcnt[m] - base[m]), 32'd0);
        end
        snap();
        xfer(8'hC3);
        check_xfer("c3", 8'hFF, 8'hC3, 1);

        // Reset in the middle of a word with a buffered TX word
        cs = '0;
        user_load(8'h77);
        send_bits(8'h3C, 3);
        ticks(2);
        rst_n = 1'b0;
        #1;
        chk("rst miso",   32'(miso),   32'h0);
        chk("rst ready",  32'(ready),  32'hF);
        chk("rst rvalid", 32'(rvalid), 32'h0);
        for (int m = 0; m < N; m++) chk($sformatf("rst m%0d rdata", m), 32'(rdata[m]), 32'h0);
`ifdef SPI_SLAVE_MISO_OE_EN
        chk("rst oe", 32'(oe), 32'h0);
`endif
        idle_lines();
        ticks(3);
        rst_n = 1'b1;
        ticks(3);
        snap();
        xfer(8'h5A);
        check_xfer("5a", 8'hFF, 8'h5A, 1);

`ifdef SPI_SLAVE_MISO_OE_EN
        chk("oe idle", 32'(oe), 32'h0);
        cs = '0;
        ticks(2);
        chk("oe fall+2", 32'(oe), 32'h0);
        ticks(1);
        chk("oe fall+3", 32'(oe), 32'hF);
        cs = '1;
        ticks(2);
        chk("oe rise+2", 32'(oe), 32'hF);
        ticks(1);
        chk("oe rise+3", 32'(oe), 32'h0);
`endif

        ticks(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
